// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: DATA/STATUS registers at BASE/BASE+1, 4-byte FIFO, 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_mmio #(
  parameter int             M          = 16,
  parameter logic [M-1:0]   BASE       = 16'hFF00,
  parameter int             DIV        = 16,
  parameter int             DEPTH_LOG2 = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] memAddr,
  input  logic [M-1:0] memWrite,
  input  logic         memWE,
  output logic [M-1:0] rdata,
  output logic         hit,
  output logic         tx
);

  localparam int             DEPTH       = 1 << DEPTH_LOG2;
  localparam int             CW          = DEPTH_LOG2 + 1;
  localparam int             BW          = $clog2(DIV);
  localparam logic [BW-1:0]  BAUD_RELOAD = BW'(DIV - 1);
  localparam logic [CW-1:0]  COUNT_FULL  = CW'(DEPTH);
  localparam logic [M-1:0]   ADDR_DATA   = BASE;
  localparam logic [M-1:0]   ADDR_STAT   = BASE + M'(1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t                r_state, w_state_next;
  logic [BW-1:0]         r_baud, w_baud_next;
  logic [2:0]            r_bit_idx, w_bit_idx_next;
  logic [7:0]            r_shift, w_shift_next;
  logic                  r_tx, w_tx_next;
`ifdef UART_TX_PARITY_EN
  logic                  r_parity, w_parity_next;
`endif

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;

  logic                  w_full, w_empty, w_busy, w_bit_end;
  logic                  w_wr_data, w_wr_stat, w_push, w_pop;
  logic [7:0]            w_head;
  logic [M-1:0]          w_status;
  logic                  w_unused;

  assign w_full    = (r_count == COUNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_busy    = (r_state != S_IDLE);
  assign w_bit_end = (r_baud == '0);
  assign w_head    = r_mem[r_rptr];
  assign w_wr_data = memWE && (memAddr == ADDR_DATA);
  assign w_wr_stat = memWE && (memAddr == ADDR_STAT);

  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign w_pop  = !w_empty && ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));
  assign w_push = w_wr_data && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= memWrite[7:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + DEPTH_LOG2'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + DEPTH_LOG2'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_wr_stat) begin
        r_ovf <= 1'b0;
      end else if (w_wr_data && !w_push) begin
        r_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
`ifdef UART_TX_PARITY_EN
      r_parity  <= w_parity_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_empty) w_state_next = S_START;
      S_START: if (w_bit_end) w_state_next = S_DATA;
`ifdef UART_TX_PARITY_EN
      S_DATA:   if (w_bit_end && r_bit_idx == 3'd7) w_state_next = S_PARITY;
      S_PARITY: if (w_bit_end) w_state_next = S_STOP;
`else
      S_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_next = S_STOP;
`endif
      S_STOP:  if (w_bit_end) w_state_next = w_empty ? S_IDLE : S_START;
      default: w_state_next = S_IDLE;
    endcase
  end

  // tx is computed from the next state so the registered line changes on the same edge as the state.
  always_comb begin
    w_baud_next    = r_baud;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
`ifdef UART_TX_PARITY_EN
    w_parity_next  = r_parity;
`endif
    if (w_pop) begin
      w_shift_next   = w_head;
      w_baud_next    = BAUD_RELOAD;
      w_bit_idx_next = '0;
`ifdef UART_TX_PARITY_EN
      w_parity_next  = ^w_head;
`endif
    end else if (r_state != S_IDLE) begin
      if (w_bit_end) begin
        w_baud_next = (w_state_next == S_IDLE) ? '0 : BAUD_RELOAD;
        if (r_state == S_DATA) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end else begin
        w_baud_next = r_baud - BW'(1);
      end
    end

    w_tx_next = 1'b1;
    case (w_state_next)
      S_START:  w_tx_next = 1'b0;
      S_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: w_tx_next = w_parity_next;
`endif
      default:  w_tx_next = 1'b1;
    endcase
  end

  assign w_status = {{(8 - CW){1'b0}}, r_count, 4'b0000, r_ovf, w_busy, w_empty, w_full};
  assign hit      = (memAddr == ADDR_DATA) || (memAddr == ADDR_STAT);
  assign rdata    = (memAddr == ADDR_STAT) ? w_status : '0;
  assign tx       = r_tx;
  assign w_unused = ^memWrite[M-1:8];

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: a line monitor decodes frames against a queue of expected bytes.
module tb_uart_tx_mmio;

  localparam int DIV = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int FRAME = (NB + 2) * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] memAddr = 16'h0000;
  logic [15:0] memWrite = 16'h0000;
  logic        memWE = 1'b0;
  logic [15:0] rdata;
  logic        hit;
  logic        tx;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .M(16), .BASE(16'hFF00), .DIV(DIV), .DEPTH_LOG2(2)
  ) dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memWE(memWE),
    .rdata(rdata), .hit(hit), .tx(tx)
  );

  int         n_vec = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    memAddr  = a;
    memWrite = d;
    memWE    = 1'b1;
    @(posedge clk);
    #1;
    memWE    = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    memAddr = a;
    memWE   = 1'b0;
    #1;
    d = rdata;
  endtask

  task automatic drain(input string tag);
    logic [15:0] st;
    int i;
    st = 16'hxxxx;
    for (i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      rd(16'hFF01, st);
      if (exp_q.size() == 0 && st == 16'h0002) break;
    end
    check({tag, "_idle_status"}, st, 16'h0002);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  // Line monitor: samples each bit at its centre, counted from the first low sample.
  int         ncyc = 0;
  int         m_cnt = 0;
  int         m_k;
  int         n_frames = 0;
  bit         m_active = 0;
  logic [7:0] m_byte;
  logic [7:0] m_exp;
`ifdef UART_TX_PARITY_EN
  logic       m_par;
`endif

  always @(negedge clk) begin
    ncyc++;
    if (!rst) begin
      m_active = 0;
    end else if (!m_active) begin
      if (tx === 1'b0) begin
        m_active = 1;
        m_cnt    = 0;
        start_q.push_back(ncyc);
      end
    end else begin
      m_cnt++;
      if (m_cnt == DIV / 2) begin
        check("mon_start_bit", tx, 0);
      end else if (m_cnt % DIV == DIV / 2) begin
        m_k = m_cnt / DIV;
        if (m_k <= 8) begin
          m_byte[m_k-1] = tx;
`ifdef UART_TX_PARITY_EN
        end else if (m_k == 9) begin
          m_par = tx;
`endif
        end else begin
          m_active = 0;
          n_frames++;
          check("mon_stop_bit", tx, 1);
          check("mon_frame_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            m_exp = exp_q.pop_front();
            $display("frame %0d: rx=%h exp=%h", n_frames, m_byte, m_exp);
            check("mon_byte", m_byte, m_exp);
`ifdef UART_TX_PARITY_EN
            check("mon_parity", m_par, ^m_exp);
`endif
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] st;
    logic [11:0] bits_v;
    int          c;

    // Reset state, combinational decode while in reset
    repeat (2) @(negedge clk);
    rd(16'hFF01, st);
    check("reset_status", st, 16'h0002);
    check("reset_tx", tx, 1);
    check("reset_hit_status", hit, 1);
    rd(16'h1234, st);
    check("miss_rdata", st, 16'h0000);
    check("miss_hit", hit, 0);
    rd(16'hFF00, st);
    check("data_read_rdata", st, 16'h0000);
    check("data_read_hit", hit, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single byte A5: cycle-exact line check
    exp_q.push_back(8'hA5);
    wr(16'hFF00, 16'h00A5);
    rd(16'hFF01, st);
    check("single_count_after_write", st, 16'h0100);
    bits_v      = '1;
    bits_v[0]   = 1'b0;
    bits_v[8:1] = 8'hA5;
`ifdef UART_TX_PARITY_EN
    bits_v[9]   = 1'b0;
`endif
    for (int k = 0; k <= FRAME; k++) begin
      @(posedge clk);
      #1;
      if (k < FRAME) check("single_tx_bit", tx, bits_v[k/DIV]);
      if (k == FRAME - 1) begin
        rd(16'hFF01, st);
        check("single_busy_last_cycle", st[2], 1);
      end
      if (k == FRAME) begin
        rd(16'hFF01, st);
        check("single_busy_cleared", st, 16'h0002);
        check("single_tx_idle", tx, 1);
      end
    end
    drain("single");

    // Overflow: six consecutive writes, the sixth is dropped
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) exp_q.push_back(8'(i));
      wr(16'hFF00, 16'(i));
    end
    rd(16'hFF01, st);
    check("ovf_status_set", st, 16'h040D);
    wr(16'hFF01, 16'hFFFF);
    rd(16'hFF01, st);
    check("ovf_status_cleared", st, 16'h0405);
    drain("ovf");

    // Back-to-back frames, count 3 -> 2 -> 1 -> 0
    start_q.delete();
    exp_q.push_back(8'h11); wr(16'hFF00, 16'h0011);
    exp_q.push_back(8'h22); wr(16'hFF00, 16'h0022);
    exp_q.push_back(8'h33); wr(16'hFF00, 16'h0033);
    exp_q.push_back(8'h44); wr(16'hFF00, 16'h0044);
    rd(16'hFF01, st);
    check("b2b_count3", st, 16'h0304);
    repeat (FRAME - 2) @(posedge clk);
    #1;
    rd(16'hFF01, st);
    check("b2b_count2", st, 16'h0204);
    repeat (FRAME) @(posedge clk);
    #1;
    rd(16'hFF01, st);
    check("b2b_count1", st, 16'h0104);
    repeat (FRAME) @(posedge clk);
    #1;
    rd(16'hFF01, st);
    check("b2b_count0", st, 16'h0006);
    drain("b2b");
    check("b2b_frames_seen", start_q.size(), 4);
    for (int i = 1; i < 4 && i < start_q.size(); i++) begin
      check("b2b_start_interval", start_q[i] - start_q[i-1], FRAME);
    end

    // Push while full, timed on the STOP-end pop
    for (int i = 1; i <= 5; i++) begin
      exp_q.push_back(8'hA0 + 8'(i));
      wr(16'hFF00, 16'h00A0 + 16'(i));
    end
    rd(16'hFF01, st);
    check("full_before_pop", st, 16'h0405);
    repeat (FRAME - 4) @(posedge clk);
    #1;
    exp_q.push_back(8'hA6);
    wr(16'hFF00, 16'h00A6);
    rd(16'hFF01, st);
    check("full_push_on_pop", st, 16'h0405);
    drain("fullpop");

    // Reset during data bit 3
    wr(16'hFF00, 16'h00C3);
    wr(16'hFF00, 16'h003C);
    wr(16'hFF00, 16'h0099);
    repeat (4 * DIV) @(posedge clk);
    #1;
    check("midframe_bit3_before_reset", tx, 0);
    rst = 1'b0;
    #1;
    check("midframe_tx_on_reset", tx, 1);
    rd(16'hFF01, st);
    check("midframe_status_on_reset", st, 16'h0002);
    @(negedge clk);
    check("midframe_tx_held", tx, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'h55);
    wr(16'hFF00, 16'h0055);
    drain("after_reset");

    // Frame length measured from busy
    exp_q.push_back(8'h07);
    wr(16'hFF00, 16'h0007);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      rd(16'hFF01, st);
      c++;
    end while (st[2] && c < 200);
    check("frame_len_busy_cycles", c, FRAME + 1);
    drain("len");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
